// File: rtl/packet_arbiter_if.sv
// Packet arbiter bus bundle.
// Carries the per-source two-phase request/acknowledge pairs with their flits
// and the shared-channel two-phase request/acknowledge pair with its flit.
//   in_req   [PORTS]       source -> arbiter, toggle request per source
//   in_ack   [PORTS]       arbiter -> source, toggle acknowledge per source
//   in_data  [PORTS*SIZE]  source flits, port i at [i*SIZE +: SIZE]
//   out_req                arbiter -> channel, toggle request
//   out_ack                channel -> arbiter, toggle acknowledge
//   out_data [SIZE]        flit forwarded to the channel
// master: environment side (sources + channel); slave: the arbiter.
interface packet_arbiter_if #(
  parameter int PORTS = 4,
  parameter int SIZE  = 8
);
  logic [PORTS-1:0]      in_req;
  logic [PORTS-1:0]      in_ack;
  logic [PORTS*SIZE-1:0] in_data;
  logic                  out_req;
  logic                  out_ack;
  logic [SIZE-1:0]       out_data;

  modport master (
    output in_req, in_data, out_ack,
    input  in_ack, out_req, out_data
  );

  modport slave (
    input  in_req, in_data, out_ack,
    output in_ack, out_req, out_data
  );
endinterface

// File: rtl/packet_arbiter.sv
// Round-robin packet arbiter: PORTS two-phase flit sources share one
// two-phase output channel. A source wins with its head flit and keeps the
// channel for FLITS flits; the next arbitration starts one past the last owner.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   bus        packet_arbiter_if.slave (source and channel handshakes, flits)
//   grant      one-hot owner of the packet in flight, zero when idle
//   pkt_count  completed packets, wraps at 16 bits
//   err        sticky: a winning first flit had no head bit
module packet_arbiter #(
  parameter int ID            = 0,
  parameter int PORTS         = 4,
  parameter int SIZE          = 8,
  parameter int FLITS         = 8,
  parameter int VERBOSE_DEBUG = 1
) (
  input  logic             clk,
  input  logic             reset,
  packet_arbiter_if.slave  bus,
  output logic [PORTS-1:0] grant,
  output logic [15:0]      pkt_count,
  output logic             err
);

  localparam int unsigned   OW        = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int unsigned   PU        = PORTS;
  localparam logic [OW-1:0] LAST_PORT = OW'(PORTS - 1);
  localparam logic [7:0]    FLITS_W   = 8'(FLITS);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, HOLD} state_e;

  state_e            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     last_owner_q, last_owner_d;
  logic [7:0]        flit_cnt_q, flit_cnt_d;
  logic              out_req_q, out_req_d;
  logic [SIZE-1:0]   out_data_q, out_data_d;
  logic [PORTS-1:0]  in_ack_q, in_ack_d;
  logic [PORTS-1:0]  grant_q, grant_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic              err_q, err_d;

  logic [PORTS-1:0]  pending;
  logic              any_pending;
  logic              chan_acked;
  logic              tail;
  logic              found;
  int unsigned       idx;
  logic [OW-1:0]     idx_w;
  logic [OW-1:0]     winner;
  logic [SIZE-1:0]   win_flit;
  logic [SIZE-1:0]   own_flit;
  logic [SIZE-1:0]   flit_arr [PORTS];

  for (genvar g = 0; g < PORTS; g++) begin : g_unpack
    assign flit_arr[g] = bus.in_data[g*SIZE +: SIZE];
  end

  // Arbitration and handshake decode shared by both combinational processes.
  always_comb begin
    pending     = bus.in_req ^ in_ack_q;
    any_pending = |pending;
    chan_acked  = (bus.out_ack == out_req_q);
    tail        = (flit_cnt_q == FLITS_W);
    found       = 1'b0;
    idx         = 0;
    idx_w       = '0;
    winner      = '0;
    // Search starts one past the last owner, so the loop runs k = 1..PORTS.
    for (int unsigned k = 1; k <= PU; k++) begin
      idx   = (32'(last_owner_q) + k) % PU;
      idx_w = OW'(idx);
      if (!found && pending[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
    win_flit = flit_arr[winner];
    own_flit = flit_arr[owner_q];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (any_pending)      state_d = WAIT_ACK;
      WAIT_ACK: if (chan_acked)       state_d = tail ? IDLE : HOLD;
      HOLD:     if (pending[owner_q]) state_d = WAIT_ACK;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    flit_cnt_d   = flit_cnt_q;
    out_req_d    = out_req_q;
    out_data_d   = out_data_q;
    in_ack_d     = in_ack_q;
    grant_d      = grant_q;
    pkt_count_d  = pkt_count_q;
    err_d        = err_q;
    unique case (state_q)
      IDLE: begin
        if (any_pending) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          out_data_d      = win_flit;
          out_req_d       = ~out_req_q;
          flit_cnt_d      = 8'd1;
          if (!win_flit[SIZE-1]) err_d = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (chan_acked) begin
          in_ack_d[owner_q] = ~in_ack_q[owner_q];
          if (tail) begin
            grant_d      = '0;
            last_owner_d = owner_q;
            pkt_count_d  = pkt_count_q + 16'd1;
          end
        end
      end
      HOLD: begin
        // Only the owner is served; other sources stay pending untouched.
        if (pending[owner_q]) begin
          out_data_d = own_flit;
          out_req_d  = ~out_req_q;
          flit_cnt_d = flit_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q      <= '0;
      last_owner_q <= LAST_PORT;
      flit_cnt_q   <= '0;
      out_req_q    <= 1'b0;
      out_data_q   <= '0;
      in_ack_q     <= '0;
      grant_q      <= '0;
      pkt_count_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      flit_cnt_q   <= flit_cnt_d;
      out_req_q    <= out_req_d;
      out_data_q   <= out_data_d;
      in_ack_q     <= in_ack_d;
      grant_q      <= grant_d;
      pkt_count_q  <= pkt_count_d;
      err_q        <= err_d;
    end
  end

  assign bus.in_ack   = in_ack_q;
  assign bus.out_req  = out_req_q;
  assign bus.out_data = out_data_q;
  assign grant        = grant_q;
  assign pkt_count    = pkt_count_q;
  assign err          = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (VERBOSE_DEBUG != 0 && reset) begin
      if (out_req_d != out_req_q)
        $display("packet_arbiter[%0d] grant=%b flit %0d/%0d data=%h",
                 ID, grant_d, flit_cnt_d, FLITS, out_data_d);
      if (pkt_count_d != pkt_count_q)
        $display("packet_arbiter[%0d] tail done owner=%0d pkt_count=%0d",
                 ID, owner_q, pkt_count_d);
    end
  end
`endif

endmodule

// File: doc/packet_arbiter.md
PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 The block SHALL provide parameter ID, default 0, instance number used in debug prints.
REQ-002 The block SHALL provide parameter PORTS, default 4, number of packet sources sharing the channel (2..8).
REQ-003 The block SHALL provide parameter SIZE, default 8, flit width; bit SIZE-1 = head marker.
REQ-004 The block SHALL provide parameter FLITS, default 8, flits per packet (1..255).
REQ-005 The block SHALL provide parameter VERBOSE_DEBUG, default 1, enabling per-flit $display.
REQ-006 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 The block SHALL have port in_req  input  PORTS  per-source two-phase (toggle) request.
REQ-009 The block SHALL have port in_ack  output  PORTS  per-source two-phase acknowledge.
REQ-010 The block SHALL have port in_data  input  PORTS*SIZE  source flits; port i at bits [i*SIZE +: SIZE].
REQ-011 The block SHALL have port out_req  output  1  shared-channel two-phase request.
REQ-012 The block SHALL have port out_ack  input  1  shared-channel two-phase acknowledge.
REQ-013 The block SHALL have port out_data  output  SIZE  flit forwarded to the channel.
REQ-014 The block SHALL have port grant  output  PORTS  one-hot current packet owner; all-zero when idle.
REQ-015 The block SHALL have port pkt_count  output  16  packets completed; wraps 0xFFFF->0.
REQ-016 The block SHALL have port err  output  1  sticky flag: first flit of a granted packet lacked the head bit.

Function
REQ-017 Port i SHALL be pending while in_req[i] != in_ack[i]; the channel SHALL be acknowledged while out_ack == out_req.
REQ-018 The FSM SHALL have states IDLE, WAIT_ACK and HOLD.
REQ-019 IDLE: if any port is pending, the winner SHALL be the first pending port searched round-robin from last_owner+1 (mod PORTS); else remain IDLE.
REQ-020 On a win: grant <= onehot(winner); out_data <= winner's flit; out_req toggles; flit_cnt <= 1; next state WAIT_ACK; all in the same edge.
REQ-021 On a win whose flit has bit SIZE-1 = 0: err <= 1; the flit SHALL still be forwarded.
REQ-022 WAIT_ACK: once the channel is acknowledged, in_ack[owner] SHALL toggle on that edge.
REQ-023 WAIT_ACK exit: if flit_cnt == FLITS -> IDLE; grant <= 0; last_owner <= owner; pkt_count +1. Otherwise -> HOLD.
REQ-024 HOLD: only the owner is considered; when it is pending, forward its flit (out_data, out_req toggle), flit_cnt +1, -> WAIT_ACK. Other ports SHALL NOT be acknowledged and SHALL stay pending.
REQ-025 Latency: a pending flit SHALL appear on out_data/out_req one edge after the pending condition is sampled; an ack return SHALL reach in_ack one edge after sampling.
REQ-026 Non-owner request toggles arriving mid-packet SHALL be held, not lost, and arbitrated in the IDLE cycle after the tail ack.
REQ-027 With a single requester, that requester SHALL win every time regardless of last_owner.
REQ-028 FLITS=1: every flit SHALL be a complete packet and SHALL return to IDLE after its ack.
REQ-029 out_data SHALL hold its value between forwards.
REQ-030 If VERBOSE_DEBUG: the block SHALL print ID, grant, each forwarded flit and each tail completion.

Reset
REQ-031 Reset low SHALL force immediately, regardless of clk: state IDLE, out_req 0, out_data 0, in_ack all 0, grant 0, flit_cnt 0, last_owner PORTS-1, pkt_count 0, err 0.
REQ-032 Reset mid-packet SHALL abandon the packet with no pkt_count increment; sources and channel SHALL be reset together.
REQ-033 After reset release, the first arbitration SHALL give port 0 priority.

Verification
REQ-034 PORTS=4, FLITS=8: only port 2 sends one packet (head 0x80 then 0x11..0x17) -> out_data carries the same 8 values in order; grant=0100 throughout; pkt_count=1; grant=0 after tail ack.
REQ-035 Ports 0 and 3 pending in the same cycle after reset -> port 0 sends all 8 flits, then port 3 is granted; port 3's flits never interleave with port 0's.
REQ-036 All 4 ports continuously pending, 3 packets each -> grant order 0,1,2,3,0,1,2,3,0,1,2,3; pkt_count=12.
REQ-037 Port 1 first flit 0x05 (no head bit) -> err=1 and remains 1; the packet is still forwarded in full.
REQ-038 Reset asserted after flit 4 of a packet -> out_req=0, in_ack=0000, grant=0, pkt_count unchanged; a new packet after release completes normally.
REQ-039 FLITS=1, channel ack delayed 5 cycles -> no second out_req toggle before the ack; the in_ack toggle follows the ack by one edge.
